// File: rtl/matrix_dripper_pkg.sv
// Shared constants and types for the matrix_dripper skew feeder.
// Optional build macro: DRIPPER_OUTREG_EN (registered p1..p4 outputs).
package matrix_dripper_pkg;
  localparam int DATA_W = 32;
  localparam int N      = 4;
  localparam int STEPS  = 2 * N - 1;

  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/matrix_dripper_lane.sv
// One row of the dripper: stores four words and emits column (count - ROW + 1), zero outside 1..4.
// Optional build macro: DRIPPER_OUTREG_EN adds one register stage on p.
module matrix_dripper_lane #(
  parameter int DATA_W = matrix_dripper_pkg::DATA_W,
  parameter int ROW    = 1
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           load,
  input  logic [5:0]                                     count,
  input  logic [matrix_dripper_pkg::N-1:0][DATA_W-1:0]   row,
  output logic [DATA_W-1:0]                              p
);
  import matrix_dripper_pkg::*;

  // Valid window for this lane is count in [ROW, ROW+N-1]; a range compare
  // keeps out-of-window counts (including 0 and 8..63) from aliasing a column.
  localparam logic [5:0] LO = 6'(ROW);
  localparam logic [5:0] HI = 6'(ROW + N - 1);

  logic [N-1:0][DATA_W-1:0] m;
  logic [1:0]               idx;
  logic [DATA_W-1:0]        sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m <= '0;
    end else if (load) begin
      m <= row;
    end
  end

  always_comb begin
    idx = 2'(count - LO);
    sel = '0;
    if (count >= LO && count <= HI) begin
      sel = m[idx];
    end
  end

`ifdef DRIPPER_OUTREG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p <= '0;
    end else begin
      p <= sel;
    end
  end
`else
  assign p = sel;
`endif
endmodule

// File: rtl/matrix_dripper.sv
// Top of the 4x4 input-skewing feeder: wires the 16 matrix inputs into four staggered lanes.
// Optional build macro: DRIPPER_OUTREG_EN (registered outputs, one extra cycle of latency).
module matrix_dripper #(
  parameter int DATA_W = matrix_dripper_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i11, i12, i13, i14,
  input  logic [DATA_W-1:0] i21, i22, i23, i24,
  input  logic [DATA_W-1:0] i31, i32, i33, i34,
  input  logic [DATA_W-1:0] i41, i42, i43, i44,
  input  logic [5:0]        count,
  input  logic              load,
  output logic [DATA_W-1:0] p1,
  output logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] p3,
  output logic [DATA_W-1:0] p4
);
  import matrix_dripper_pkg::*;

  logic [N-1:0][N-1:0][DATA_W-1:0] rows;
  logic [N-1:0][DATA_W-1:0]        lane_p;

  // rows[r][c] holds element (r+1, c+1).
  assign rows[0] = {i14, i13, i12, i11};
  assign rows[1] = {i24, i23, i22, i21};
  assign rows[2] = {i34, i33, i32, i31};
  assign rows[3] = {i44, i43, i42, i41};

  for (genvar r = 0; r < N; r++) begin : g_lane
    matrix_dripper_lane #(
      .DATA_W (DATA_W),
      .ROW    (r + 1)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .count (count),
      .row   (rows[r]),
      .p     (lane_p[r])
    );
  end

  assign p1 = lane_p[0];
  assign p2 = lane_p[1];
  assign p3 = lane_p[2];
  assign p4 = lane_p[3];
endmodule

// File: tb/tb_matrix_dripper.sv
// Self-checking bench for matrix_dripper: directed test-plan steps plus random traffic vs. a matrix model.
// Honors DRIPPER_OUTREG_EN by expecting the value selected before each edge.
module tb_matrix_dripper;
  import matrix_dripper_pkg::*;
  localparam int W = DATA_W;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         load;
  logic [5:0]   count;
  logic [W-1:0] in_m [4][4];
  logic [W-1:0] p1, p2, p3, p4;

  matrix_dripper #(.DATA_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i11 (in_m[0][0]), .i12 (in_m[0][1]), .i13 (in_m[0][2]), .i14 (in_m[0][3]),
    .i21 (in_m[1][0]), .i22 (in_m[1][1]), .i23 (in_m[1][2]), .i24 (in_m[1][3]),
    .i31 (in_m[2][0]), .i32 (in_m[2][1]), .i33 (in_m[2][2]), .i34 (in_m[2][3]),
    .i41 (in_m[3][0]), .i42 (in_m[3][1]), .i43 (in_m[3][2]), .i44 (in_m[3][3]),
    .count (count),
    .load  (load),
    .p1 (p1), .p2 (p2), .p3 (p3), .p4 (p4)
  );

  // reference model: the stored matrix plus the skew rule in plain arithmetic
  word_t ref_m [4][4];
  int    checks = 0;
  int    errors = 0;

  function automatic word_t drip(int r, int cnt);
    int c;
    c = cnt - r + 1;
    if (c >= 1 && c <= 4) return ref_m[r-1][c-1];
    return '0;
  endfunction

  // driver + scoreboard: apply one cycle, then check all four lanes after the edge
  task automatic tick(input string tag, input logic rst_v, input logic load_v, input int cnt);
    word_t pre [4];
    word_t post [4];
    word_t got [4];
    word_t exp_v;
    rst_n = rst_v;
    load  = load_v;
    count = 6'(cnt);
    for (int r = 0; r < 4; r++) pre[r] = drip(r + 1, cnt);
    @(posedge clk);
    if (!rst_v) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) ref_m[r][c] = '0;
    end else if (load_v) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) ref_m[r][c] = in_m[r][c];
    end
    for (int r = 0; r < 4; r++) post[r] = drip(r + 1, cnt);
    #1;
    got[0] = p1; got[1] = p2; got[2] = p3; got[3] = p4;
    for (int r = 0; r < 4; r++) begin
`ifdef DRIPPER_OUTREG_EN
      exp_v = rst_v ? pre[r] : '0;
`else
      exp_v = post[r];
`endif
      checks++;
      assert (got[r] === exp_v) else begin
        errors++;
        $error("FAIL %s p%0d count=%0d observed %h expected %h", tag, r + 1, cnt, got[r], exp_v);
      end
    end
  endtask

  task automatic fill_random();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) in_m[r][c] = W'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    count = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        in_m[r][c]  = W'($urandom);
        ref_m[r][c] = '0;
      end

    // reset, then sweep: all zero
    tick("reset", 1'b0, 1'b0, 0);
    tick("reset", 1'b0, 1'b0, 5);
    for (int k = 0; k <= 7; k++) tick("zero_sweep", 1'b1, 1'b0, k);

    // identity with diagonal ffff
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) in_m[r][c] = (r == c) ? W'(32'hffff) : '0;
    tick("load_ident", 1'b1, 1'b1, 0);
    fill_random();
    for (int k = 1; k <= 7; k++) tick("diag", 1'b1, 1'b0, k);
    tick("diag", 1'b1, 1'b0, 0);

    // element (r,c) = 0xrc
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) in_m[r][c] = W'((r + 1) * 16 + (c + 1));
    tick("load_rc", 1'b1, 1'b1, 0);
    fill_random();
    tick("rc_c4", 1'b1, 1'b0, 4);
    tick("rc_c6", 1'b1, 1'b0, 6);
    tick("rc_c0", 1'b1, 1'b0, 0);
    tick("rc_c8", 1'b1, 1'b0, 8);
    tick("rc_c63", 1'b1, 1'b0, 63);
    tick("rc_c8b", 1'b1, 1'b0, 8);
    for (int k = 1; k <= 9; k++) tick("rc_sweep", 1'b1, 1'b0, k);

    // matrix A mid-stream replaced by B, then reset mid-stream
    fill_random();
    tick("load_a", 1'b1, 1'b1, 1);
    tick("stream_a", 1'b1, 1'b0, 2);
    tick("stream_a", 1'b1, 1'b0, 3);
    fill_random();
    tick("load_b", 1'b1, 1'b1, 3);
    fill_random();
    tick("stream_b", 1'b1, 1'b0, 3);
    tick("stream_b", 1'b1, 1'b0, 4);
    tick("mid_reset", 1'b0, 1'b0, 4);
    for (int k = 3; k <= 7; k++) tick("post_reset", 1'b1, 1'b0, k);

    // reset beats load on the same edge
    fill_random();
    tick("load_a2", 1'b1, 1'b1, 0);
    tick("stream_a2", 1'b1, 1'b0, 4);
    fill_random();
    tick("rst_and_load", 1'b0, 1'b1, 4);
    tick("rst_and_load", 1'b1, 1'b0, 4);
    tick("rst_and_load", 1'b1, 1'b0, 5);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic rv, lv;
      int   cv;
      fill_random();
      rv = ($urandom_range(0, 39) != 0);
      lv = ($urandom_range(0, 5) == 0);
      cv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 9));
      tick("random", rv, lv, cv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/matrix_dripper.md
# matrix_dripper

Input-skewing feeder for a 4×4 systolic array. It captures a 4×4 matrix of 32-bit words in one load cycle. It then drips the matrix out as four diagonally staggered row streams, one word per row per step, selected by an externally supplied step counter. Each row r (1..4) is delayed by r−1 steps, so a wavefront enters the array edge correctly aligned.

## Interface
- DATA_W, default 32, word width of every matrix element and output lane.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous and active-low.
- i11..i44  input  DATA_W each (16 ports)  matrix element, row=first digit, column=second digit.
- count  input  6  step index driven by the controller. Valid steps are 1..7.
- load  input  1  when high at a rising edge, all 16 inputs are captured.
- p1, p2, p3, p4  output  DATA_W each  skewed stream for rows 1..4.

## Operation
- Internal storage: 16 registers m[r][c] of DATA_W bits.
- Reset (rst_n=0 at posedge): all m[r][c] ← 0.
- Load (rst_n=1, load=1 at posedge): m[r][c] ← i_rc for all 16 elements simultaneously.
  - Load has priority over streaming. A load during a stream replaces the matrix immediately.
- No load: storage holds its value. Inputs i_rc are ignored.
- Output rule, for each lane r: column index c = count − r + 1.
  - If 1 ≤ c ≤ 4: p_r = m[r][c].
  - Otherwise p_r = 0.
- Resulting schedule:
  - p1 is active at counts 1–4.
  - p2 at counts 2–5.
  - p3 at counts 3–6.
  - p4 at counts 4–7.
- count = 0 and counts 8..63 give all-zero outputs. There is no wrap-around or modulo.
- Arithmetic: the subtraction is done in at least 7 bits signed, or as an equivalent range compare, so no negative index aliases to a valid column.
- The block holds no counter of its own. Step sequencing belongs to the controller.

## Timing
- Storage updates only on the rising edge of clk.
- Default build: outputs are combinational from the stored matrix and the current count.
  - A new count is reflected in the same cycle.
  - Freshly loaded data is visible from the cycle after the load edge.
- Reset values: p1..p4 = 0. This holds immediately after reset because storage is zero, for any count.
- Reset mid-stream clears storage. From the next cycle all outputs are 0 regardless of count.
- Simultaneous reset and load: reset wins.

## Configuration
- DRIPPER_OUTREG_EN defined:
  - p1..p4 are registered. At each posedge, p_r ← the value the output rule gives for the count and storage before that edge.
  - This adds exactly one cycle of latency.
  - Output registers reset to 0 under rst_n.
  - A load and a stream step on the same edge output the old matrix's element.
- Undefined: outputs are combinational as described above.

## Structure
- Shared package holds:
  - DATA_W default.
  - N = 4 (matrix dimension).
  - STEPS = 2N−1 = 7.
  - Element typedef word_t = logic [DATA_W-1:0].
- Natural sub-module: dripper_lane, instantiated four times with a row-offset parameter.
  - Holds one row of 4 words.
  - Performs the c = count − r + 1 select with zero fill.
  - Optionally holds the output register.
- The top level only fans out load/reset and wires the 16 inputs into four lanes.

## Test plan
- Reset then sweep count 0..7 → all outputs 0 at every step.
- Load identity with diagonal 32'hffff, then count 1..7:
  - count 1: p1=ffff, others 0.
  - count 3: p2=ffff, others 0.
  - count 5: p3=ffff, others 0.
  - count 7: p4=ffff, others 0.
  - counts 2, 4, 6: all 0.
- Load m[r][c]=32'h00000rc (e.g. i23=0x23), then count=4 → p1=0x14, p2=0x23, p3=0x32, p4=0x41.
  - Same load, count=6 → p1=0, p2=0, p3=0x34, p4=0x43.
- Same matrix, count=0, 8 and 63 → all outputs 0. Count 8 must not alias to column 1 of p4.
- Load matrix A, stream to count=3, then load matrix B → from the next cycle outputs follow B (p1=B13, p2=B22, p3=B31).
  - Then assert rst_n=0 for one cycle → all outputs 0 afterwards.
- With DRIPPER_OUTREG_EN: repeat the diagonal test → each value appears one cycle later than in the combinational build; outputs are 0 out of reset.
